// File: rtl/instr_exec_unit.sv
// Execution stage: single-cycle ZERO/PASS/ADD/SUB, iterative shift-add multiply and
// restoring divide/modulo, result returned on a valid/ready port tagged with its source.
module instr_exec_unit #(
   parameter int OP_W  = 32,
   parameter int RES_W = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_opc,
   input  logic [OP_W-1:0]  in_op_a,
   input  logic [OP_W-1:0]  in_op_b,
   input  logic [4:0]       in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] out_result,
   output logic [4:0]       out_tag,
   output logic             out_err,
   output logic [CNT_W-1:0] op_count
);

   localparam int CW = $clog2(OP_W);

   localparam logic [3:0] OPC_ZERO  = 4'd0;
   localparam logic [3:0] OPC_PASSA = 4'd1;
   localparam logic [3:0] OPC_PASSB = 4'd2;
   localparam logic [3:0] OPC_ADD   = 4'd3;
   localparam logic [3:0] OPC_SUB   = 4'd4;
   localparam logic [3:0] OPC_MULT  = 4'd5;
   localparam logic [3:0] OPC_DIV   = 4'd6;
   localparam logic [3:0] OPC_MOD   = 4'd7;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIXUP, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_opc;
   logic [CW-1:0]     r_cnt;
   logic [OP_W-1:0]   r_mag_b;
   logic [RES_W-1:0]  r_acc;
   logic              r_neg_res;

   logic              w_accept;
   logic              w_b_zero;
   logic              w_is_divmod;
   logic              w_iter_op;
   logic              w_fast_err;
   logic [RES_W-1:0]  w_a_ext;
   logic [RES_W-1:0]  w_b_ext;
   logic [RES_W-1:0]  w_fast_res;
   logic [OP_W-1:0]   w_mag_a;
   logic [OP_W-1:0]   w_mag_b;
   logic [OP_W-1:0]   w_mul_add;
   logic [OP_W:0]     w_mul_sum;
   logic [RES_W-1:0]  w_mul_nxt;
   logic [OP_W:0]     w_div_rs;
   logic              w_div_ge;
   logic [OP_W-1:0]   w_div_sub;
   logic [OP_W-1:0]   w_div_rem;
   logic [RES_W-1:0]  w_div_nxt;
   logic [RES_W-1:0]  w_mag_res;
   logic [RES_W-1:0]  w_fix_res;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);

   assign w_accept    = in_valid & in_ready;
   assign w_b_zero    = (in_op_b == {OP_W{1'b0}});
   assign w_is_divmod = (in_opc == OPC_DIV) || (in_opc == OPC_MOD);
   assign w_iter_op   = (in_opc == OPC_MULT) || (w_is_divmod && !w_b_zero);
   assign w_fast_err  = in_opc[3] || (w_is_divmod && w_b_zero);

   assign w_a_ext = {{(RES_W-OP_W){in_op_a[OP_W-1]}}, in_op_a};
   assign w_b_ext = {{(RES_W-OP_W){in_op_b[OP_W-1]}}, in_op_b};
   assign w_mag_a = in_op_a[OP_W-1] ? -in_op_a : in_op_a;
   assign w_mag_b = in_op_b[OP_W-1] ? -in_op_b : in_op_b;

   // Shift-add multiply: multiplier sits in the low half and shifts out LSB first.
   assign w_mul_add = r_acc[0] ? r_mag_b : {OP_W{1'b0}};
   assign w_mul_sum = {1'b0, r_acc[RES_W-1:OP_W]} + {1'b0, w_mul_add};
   assign w_mul_nxt = {w_mul_sum, r_acc[OP_W-1:1]};

   // Restoring divide: remainder in the high half, quotient bits enter at the LSB.
   assign w_div_rs  = r_acc[RES_W-1:OP_W-1];
   assign w_div_ge  = (w_div_rs >= {1'b0, r_mag_b});
   assign w_div_sub = w_div_rs[OP_W-1:0] - r_mag_b;
   assign w_div_rem = w_div_ge ? w_div_sub : w_div_rs[OP_W-1:0];
   assign w_div_nxt = {w_div_rem, r_acc[OP_W-2:0], w_div_ge};

   // Single-cycle result selection.
   always_comb begin
      w_fast_res = {RES_W{1'b0}};
      case (in_opc)
         OPC_ZERO:  w_fast_res = {RES_W{1'b0}};
         OPC_PASSA: w_fast_res = w_a_ext;
         OPC_PASSB: w_fast_res = w_b_ext;
         OPC_ADD:   w_fast_res = w_a_ext + w_b_ext;
         OPC_SUB:   w_fast_res = w_a_ext - w_b_ext;
         default:   w_fast_res = {RES_W{1'b0}};
      endcase
   end

   // Sign fixup of the unsigned iterative result.
   always_comb begin
      w_mag_res = r_acc;
      if (r_opc == OPC_DIV) begin
         w_mag_res = {{(RES_W-OP_W){1'b0}}, r_acc[OP_W-1:0]};
      end else if (r_opc == OPC_MOD) begin
         w_mag_res = {{(RES_W-OP_W){1'b0}}, r_acc[RES_W-1:OP_W]};
      end else begin
         w_mag_res = r_acc;
      end
      w_fix_res = r_neg_res ? -w_mag_res : w_mag_res;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_iter_op ? S_ITER : S_DONE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ITER: begin
            if (r_cnt == CW'(OP_W-1)) begin
               w_state_nxt = S_FIXUP;
            end else begin
               w_state_nxt = S_ITER;
            end
         end
         S_FIXUP: w_state_nxt = S_DONE;
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath, output and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_opc      <= 4'd0;
         r_cnt      <= {CW{1'b0}};
         r_mag_b    <= {OP_W{1'b0}};
         r_acc      <= {RES_W{1'b0}};
         r_neg_res  <= 1'b0;
         out_result <= {RES_W{1'b0}};
         out_tag    <= 5'd0;
         out_err    <= 1'b0;
         op_count   <= {CNT_W{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_opc     <= in_opc;
                  out_tag   <= in_tag;
                  out_err   <= w_fast_err;
                  r_cnt     <= {CW{1'b0}};
                  r_mag_b   <= w_mag_b;
                  r_neg_res <= (in_opc == OPC_MOD) ? in_op_a[OP_W-1]
                                                   : (in_op_a[OP_W-1] ^ in_op_b[OP_W-1]);
                  if (w_iter_op) begin
                     r_acc <= {{(RES_W-OP_W){1'b0}}, w_mag_a};
                  end else begin
                     out_result <= w_fast_res;
                  end
               end
            end
            S_ITER: begin
               r_acc <= (r_opc == OPC_MULT) ? w_mul_nxt : w_div_nxt;
               r_cnt <= r_cnt + CW'(1);
            end
            S_FIXUP: out_result <= w_fix_res;
            S_DONE: begin
               if (out_ready) begin
                  op_count <= op_count + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Scoreboard bench for instr_exec_unit: expected results are queued at drive time
// from a longint reference model and compared when the unit presents its result.
module tb_instr_exec_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opc;
   logic [31:0] in_op_a;
   logic [31:0] in_op_b;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [4:0]  out_tag;
   logic        out_err;
   logic [15:0] op_count;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  tag;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_cnt = 16'd0;

   instr_exec_unit dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
      .in_op_a(in_op_a), .in_op_b(in_op_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .out_err(out_err), .op_count(op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] opc, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] tag);
      exp_t   e;
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.tag = tag;
      e.err = 1'b0;
      e.lat = 1;
      e.res = 64'd0;
      case (opc)
         4'd0: e.res = 64'd0;
         4'd1: e.res = sa;
         4'd2: e.res = sb;
         4'd3: e.res = sa + sb;
         4'd4: e.res = sa - sb;
         4'd5: begin e.res = sa * sb; e.lat = 34; end
         4'd6: if (sb == 0) e.err = 1'b1; else begin e.res = sa / sb; e.lat = 34; end
         4'd7: if (sb == 0) e.err = 1'b1; else begin e.res = sa % sb; e.lat = 34; end
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   task automatic do_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold);
      exp_t        e;
      int          lat;
      int          w;
      logic [63:0] held_res;
      sb_q.push_back(model(opc, a, b, tag));
      out_ready = (hold == 0);
      @(negedge clk);
      in_valid = 1'b1; in_opc = opc; in_op_a = a; in_op_b = b; in_tag = tag;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      e = sb_q.pop_front();
      check_eq("latency", 64'(lat), 64'(e.lat));
      check_eq("result", out_result, e.res);
      check_eq("tag", 64'(out_tag), 64'(e.tag));
      check_eq("err", 64'(out_err), 64'(e.err));
      check_eq("in_ready_busy", 64'(in_ready), 64'd0);
      held_res = out_result;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_opc = 4'd3; in_op_a = 32'd100; in_op_b = 32'd200; in_tag = 5'd9;
         @(posedge clk);
         #1;
         check_eq("bp_valid", 64'(out_valid), 64'd1);
         check_eq("bp_result", out_result, held_res);
         check_eq("bp_tag", 64'(out_tag), 64'(e.tag));
         check_eq("bp_in_ready", 64'(in_ready), 64'd0);
         check_eq("bp_count", 64'(op_count), 64'(exp_cnt));
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_cnt++;
      check_eq("op_count", 64'(op_count), 64'(exp_cnt));
      check_eq("idle_after", 64'(out_valid), 64'd0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_opc = 4'd0; in_op_a = 32'd0; in_op_b = 32'd0;
      in_tag = 5'd0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_result", out_result, 64'd0);
      check_eq("rst_tag", 64'(out_tag), 64'd0);
      check_eq("rst_err", 64'(out_err), 64'd0);
      check_eq("rst_count", 64'(op_count), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      do_op(4'd3, -32'sd15, 32'sd7, 5'd3, 0);
      check_eq("add_const", out_result, 64'hFFFF_FFFF_FFFF_FFF8);
      do_op(4'd5, -32'sd7, 32'sd13, 5'd31, 0);
      do_op(4'd5, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
      do_op(4'd6, -32'sd15, 32'sd4, 5'd2, 0);
      do_op(4'd7, -32'sd15, 32'sd4, 5'd4, 0);
      do_op(4'd7, 32'sd15, -32'sd4, 5'd6, 0);
      do_op(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
      do_op(4'd6, 32'sd9, 32'sd0, 5'd8, 0);
      do_op(4'd12, 32'sd1, 32'sd2, 5'd10, 0);
      do_op(4'd4, 32'sd5, 32'sd9, 5'd11, 0);
      do_op(4'd1, 32'sd11, 32'sd0, 5'd5, 10);
      for (int k = 0; k < 8; k++) begin
         do_op(4'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)), 0);
      end
      do_op(4'd5, 32'h7FFF_FFFF, 32'h8000_0001, 5'd12, 0);
      do_op(4'd7, 32'sd1000003, 32'sd97, 5'd13, 0);

      // Abort a divide mid-iteration with reset.
      @(negedge clk);
      in_valid = 1'b1; in_opc = 4'd6; in_op_a = 32'sd12345; in_op_b = 32'sd7; in_tag = 5'd14;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_cnt = 16'd0;
      check_eq("abort_in_ready", 64'(in_ready), 64'd1);
      check_eq("abort_out_valid", 64'(out_valid), 64'd0);
      check_eq("abort_count", 64'(op_count), 64'd0);
      check_eq("abort_result", out_result, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      do_op(4'd2, 32'sd0, 32'sd6, 5'd15, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
